lut7_cfg_ctrl: RTL and testbench

- Runtime-reconfigurable 7-input lookup resource with a configuration loader and a two-requester lookup arbiter.
- Holds a 128-bit active truth table, equivalent to a LUT7 INIT vector, and a 128-bit shadow table.
- The shadow table is loaded as eight 16-bit words, then committed atomically into the active table.
- Two requesters share the active table through round-robin arbitration; results are registered.

---
 rtl/lut7_cfg_ctrl.sv | 93 +++++++++
 tb/tb_lut7_cfg_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut7_cfg_ctrl.sv
// rtl/lut7_cfg_ctrl.sv - LUT7 truth table with shadow config loader and two-port round-robin lookup
// Shadow words load in any order; LAST commits the whole shadow into the active table in one cycle.
module lut7_cfg_ctrl #(
  parameter logic [127:0] INIT = 128'h0
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [2:0]  CFG_ADDR,
  input  logic [15:0] CFG_DATA,
  input  logic        CFG_LAST,
  output logic        COMMIT_DONE,
  input  logic        REQ0_VALID,
  input  logic [6:0]  REQ0_IDX,
  output logic        REQ0_READY,
  input  logic        REQ1_VALID,
  input  logic [6:0]  REQ1_IDX,
  output logic        REQ1_READY,
  output logic        RSP_VALID,
  output logic        RSP_ID,
  output logic        RSP_F
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] active;
  logic [127:0] shadow;
  logic         rr;
  logic         open;
  logic         cfg_accept;
  logic         grant0;
  logic         grant1;

  // Handshakes are held off in reset and for the single COMMIT cycle.
  always_comb begin
    state_nxt  = state;
    open       = RESETN && (state != COMMIT);
    cfg_accept = CFG_VALID && open;
    grant0     = open && REQ0_VALID && (!REQ1_VALID || !rr);
    grant1     = open && REQ1_VALID && (!REQ0_VALID || rr);
    case (state)
      IDLE, LOAD: begin
        if (cfg_accept) state_nxt = CFG_LAST ? COMMIT : LOAD;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign CFG_READY  = open;
  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= IDLE;
      active      <= INIT;
      shadow      <= INIT;
      rr          <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_ID      <= 1'b0;
      RSP_F       <= 1'b0;
      COMMIT_DONE <= 1'b0;
    end else begin
      state       <= state_nxt;
      COMMIT_DONE <= (state == COMMIT);
      if (state == COMMIT) active <= shadow;
      if (cfg_accept) shadow[{CFG_ADDR, 4'b0000} +: 16] <= CFG_DATA;
      // Lookups read the active table only, so a LAST-cycle grant still sees the old table.
      if (grant0) begin
        RSP_VALID <= 1'b1;
        RSP_ID    <= 1'b0;
        RSP_F     <= active[REQ0_IDX];
        rr        <= 1'b1;
      end else if (grant1) begin
        RSP_VALID <= 1'b1;
        RSP_ID    <= 1'b1;
        RSP_F     <= active[REQ1_IDX];
        rr        <= 1'b0;
      end else begin
        RSP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lut7_cfg_ctrl.sv
// tb/tb_lut7_cfg_ctrl.sv - bench for lut7_cfg_ctrl against a behavioural table/arbiter model
module tb_lut7_cfg_ctrl;

  localparam logic [127:0] INIT_V = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        CFG_VALID = 1'b0;
  logic        CFG_READY;
  logic [2:0]  CFG_ADDR = 3'd0;
  logic [15:0] CFG_DATA = 16'd0;
  logic        CFG_LAST = 1'b0;
  logic        COMMIT_DONE;
  logic        REQ0_VALID = 1'b0;
  logic [6:0]  REQ0_IDX = 7'd0;
  logic        REQ0_READY;
  logic        REQ1_VALID = 1'b0;
  logic [6:0]  REQ1_IDX = 7'd0;
  logic        REQ1_READY;
  logic        RSP_VALID;
  logic        RSP_ID;
  logic        RSP_F;

  lut7_cfg_ctrl #(.INIT(INIT_V)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA), .CFG_LAST(CFG_LAST), .COMMIT_DONE(COMMIT_DONE),
    .REQ0_VALID(REQ0_VALID), .REQ0_IDX(REQ0_IDX), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_IDX(REQ1_IDX), .REQ1_READY(REQ1_READY),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_F(RSP_F)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tables as plain vectors, a pending-commit flag and a preferred requester.
  logic [127:0] m_active, m_shadow;
  logic         m_commit, m_done;
  int           m_pref;
  logic         m_rsp_valid, m_rsp_id, m_rsp_f;
  logic         exp_cfg_ready, exp_r0, exp_r1;
  logic         obs_cfg_ready, obs_r0, obs_r1;
  logic [127:0] obs_table;

  task automatic model_reset();
    m_active = INIT_V; m_shadow = INIT_V;
    m_commit = 1'b0; m_done = 1'b0; m_pref = 0;
    m_rsp_valid = 1'b0; m_rsp_id = 1'b0; m_rsp_f = 1'b0;
  endtask

  task automatic idle_inputs();
    CFG_VALID = 1'b0; CFG_LAST = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
  endtask

  task automatic tick();
    logic g0, g1;
    @(negedge CLK);
    exp_cfg_ready = !m_commit;
    g0 = !m_commit && REQ0_VALID && (!REQ1_VALID || m_pref == 0);
    g1 = !m_commit && REQ1_VALID && (!REQ0_VALID || m_pref == 1);
    exp_r0 = g0; exp_r1 = g1;
    obs_cfg_ready = CFG_READY; obs_r0 = REQ0_READY; obs_r1 = REQ1_READY;
    @(posedge CLK);
    m_done = m_commit;
    if (g0) begin
      m_rsp_valid = 1'b1; m_rsp_id = 1'b0; m_rsp_f = m_active[REQ0_IDX]; m_pref = 1;
    end else if (g1) begin
      m_rsp_valid = 1'b1; m_rsp_id = 1'b1; m_rsp_f = m_active[REQ1_IDX]; m_pref = 0;
    end else begin
      m_rsp_valid = 1'b0;
    end
    if (m_commit) begin
      m_active = m_shadow; m_commit = 1'b0;
    end else if (CFG_VALID) begin
      m_shadow[int'(CFG_ADDR)*16 +: 16] = CFG_DATA;
      if (CFG_LAST) m_commit = 1'b1;
    end
    #1;
  endtask

  task automatic assert_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  task automatic release_reset();
    idle_inputs();
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic read_all();
    CFG_VALID = 1'b0; REQ1_VALID = 1'b0; REQ0_VALID = 1'b1;
    for (int i = 0; i < 128; i++) begin
      REQ0_IDX = i[6:0];
      tick();
      obs_table[i] = RSP_F;
    end
    REQ0_VALID = 1'b0;
  endtask

  task automatic cfg_word(input logic [2:0] a, input logic [15:0] d, input logic last);
    CFG_VALID = 1'b1; CFG_ADDR = a; CFG_DATA = d; CFG_LAST = last;
  endtask

  task automatic test_reset();
    assert_reset();
    CFG_VALID = 1'b1; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #2;
    n_cmp++; if (CFG_READY !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_ready got %b want 0", CFG_READY); end
    n_cmp++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b%b want 00", REQ0_READY, REQ1_READY); end
    n_cmp++; if (RSP_VALID !== 1'b0 || RSP_ID !== 1'b0 || RSP_F !== 1'b0) begin n_bad++; $display("FAIL reset_rsp got v%b id%b f%b want 000", RSP_VALID, RSP_ID, RSP_F); end
    n_cmp++; if (COMMIT_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_commit_done got %b want 0", COMMIT_DONE); end
    release_reset();
  endtask

  task automatic test_init_lookup();
    logic [6:0] idxs [3] = '{7'd0, 7'd127, 7'd64};
    logic       fs   [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      REQ0_VALID = 1'b1; REQ0_IDX = idxs[i];
      tick();
      n_cmp++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin n_bad++; $display("FAIL init_grant idx%0d got %b%b want 10", idxs[i], obs_r0, obs_r1); end
      n_cmp++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b0 || RSP_F !== fs[i]) begin n_bad++; $display("FAIL init_lookup idx%0d got v%b id%b f%b want v1 id0 f%b", idxs[i], RSP_VALID, RSP_ID, RSP_F, fs[i]); end
    end
    REQ0_VALID = 1'b0;
    tick();
    n_cmp++; if (RSP_VALID !== 1'b0 || RSP_F !== m_rsp_f) begin n_bad++; $display("FAIL init_hold got v%b f%b want v0 f%b", RSP_VALID, RSP_F, m_rsp_f); end
  endtask

  task automatic test_full_load();
    for (int k = 0; k < 8; k++) begin
      cfg_word(k[2:0], 16'hAAAA, k == 7);
      if (k == 7) begin REQ0_VALID = 1'b1; REQ0_IDX = 7'd0; end
      tick();
      n_cmp++; if (obs_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready word%0d got %b want 1", k, obs_cfg_ready); end
      n_cmp++; if (COMMIT_DONE !== 1'b0) begin n_bad++; $display("FAIL load_early_done word%0d got %b want 0", k, COMMIT_DONE); end
    end
    n_cmp++; if (RSP_VALID !== 1'b1 || RSP_F !== 1'b1) begin n_bad++; $display("FAIL last_cycle_old_table got v%b f%b want v1 f1", RSP_VALID, RSP_F); end
    CFG_VALID = 1'b1; CFG_LAST = 1'b0; REQ0_IDX = 7'd5;
    tick();
    n_cmp++; if (obs_cfg_ready !== 1'b0 || obs_r0 !== 1'b0) begin n_bad++; $display("FAIL commit_ready got cfg%b req0%b want 00", obs_cfg_ready, obs_r0); end
    n_cmp++; if (COMMIT_DONE !== 1'b1 || RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL commit_done got done%b v%b want done1 v0", COMMIT_DONE, RSP_VALID); end
    CFG_VALID = 1'b0;
    tick();
    n_cmp++; if (obs_cfg_ready !== 1'b1 || RSP_F !== 1'b1 || COMMIT_DONE !== 1'b0) begin n_bad++; $display("FAIL after_commit_idx5 got rdy%b f%b done%b want 1 1 0", obs_cfg_ready, RSP_F, COMMIT_DONE); end
    REQ0_IDX = 7'd6;
    tick();
    n_cmp++; if (RSP_VALID !== 1'b1 || RSP_F !== 1'b0) begin n_bad++; $display("FAIL after_commit_idx6 got v%b f%b want v1 f0", RSP_VALID, RSP_F); end
    REQ0_VALID = 1'b0;
  endtask

  task automatic test_round_robin();
    REQ1_VALID = 1'b1; REQ1_IDX = 7'($urandom_range(0, 127));
    tick();
    n_cmp++; if (obs_r1 !== 1'b1 || RSP_ID !== 1'b1) begin n_bad++; $display("FAIL rr_single1 got r1%b id%b want 11", obs_r1, RSP_ID); end
    REQ0_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      REQ0_IDX = 7'($urandom_range(0, 127)); REQ1_IDX = 7'($urandom_range(0, 127));
      tick();
      n_cmp++; if (obs_r0 !== (i % 2 == 0) || obs_r1 !== (i % 2 == 1) || obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin n_bad++; $display("FAIL rr_grant cyc%0d got %b%b want %b%b", i, obs_r0, obs_r1, exp_r0, exp_r1); end
      n_cmp++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'(i % 2) || RSP_F !== m_rsp_f) begin n_bad++; $display("FAIL rr_rsp cyc%0d got v%b id%b f%b want v1 id%0d f%b", i, RSP_VALID, RSP_ID, RSP_F, i % 2, m_rsp_f); end
    end
    idle_inputs();
  endtask

  task automatic test_partial();
    logic [127:0] expt;
    expt = m_active;
    expt[63:48] = 16'h0001;
    cfg_word(3'd3, 16'h0001, 1'b1);
    tick();
    CFG_VALID = 1'b0;
    tick();
    n_cmp++; if (COMMIT_DONE !== 1'b1) begin n_bad++; $display("FAIL partial_done got %b want 1", COMMIT_DONE); end
    read_all();
    n_cmp++; if (obs_table !== expt || obs_table !== m_active) begin n_bad++; $display("FAIL partial_table got %h want %h", obs_table, expt); end
  endtask

  task automatic test_repeat_addr();
    cfg_word(3'd2, 16'h1234, 1'b0);
    tick();
    cfg_word(3'd2, 16'h5678, 1'b1);
    tick();
    CFG_VALID = 1'b0;
    tick();
    read_all();
    n_cmp++; if (obs_table[47:32] !== 16'h5678 || obs_table !== m_active) begin n_bad++; $display("FAIL repeat_addr got %h want word2 5678 of %h", obs_table, m_active); end
  endtask

  task automatic test_reset_midload();
    logic [127:0] expt;
    logic [15:0]  d;
    for (int k = 4; k < 8; k++) begin
      cfg_word(k[2:0], 16'($urandom), 1'b0);
      tick();
    end
    assert_reset();
    release_reset();
    d = 16'($urandom);
    cfg_word(3'd0, d, 1'b1);
    tick();
    n_cmp++; if (COMMIT_DONE !== 1'b0) begin n_bad++; $display("FAIL midload_no_early_done got %b want 0", COMMIT_DONE); end
    CFG_VALID = 1'b0;
    tick();
    n_cmp++; if (COMMIT_DONE !== 1'b1) begin n_bad++; $display("FAIL midload_done got %b want 1", COMMIT_DONE); end
    read_all();
    expt = INIT_V;
    expt[15:0] = d;
    n_cmp++; if (obs_table !== expt) begin n_bad++; $display("FAIL midload_table got %h want %h", obs_table, expt); end
    cfg_word(3'd1, 16'hFFFF, 1'b1);
    tick();
    assert_reset();
    release_reset();
    read_all();
    n_cmp++; if (obs_table !== INIT_V) begin n_bad++; $display("FAIL reset_in_commit got %h want %h", obs_table, INIT_V); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      CFG_VALID  = ($urandom_range(0, 2) == 0);
      CFG_ADDR   = 3'($urandom);
      CFG_DATA   = 16'($urandom);
      CFG_LAST   = ($urandom_range(0, 3) == 0);
      REQ0_VALID = 1'($urandom);
      REQ1_VALID = 1'($urandom);
      REQ0_IDX   = 7'($urandom);
      REQ1_IDX   = 7'($urandom);
      tick();
      n_cmp++;
      if (obs_cfg_ready !== exp_cfg_ready || obs_r0 !== exp_r0 || obs_r1 !== exp_r1 ||
          RSP_VALID !== m_rsp_valid || RSP_ID !== m_rsp_id || RSP_F !== m_rsp_f || COMMIT_DONE !== m_done) begin
        n_bad++;
        $display("FAIL random cyc%0d got rdy%b r%b%b v%b id%b f%b done%b want rdy%b r%b%b v%b id%b f%b done%b",
                 c, obs_cfg_ready, obs_r0, obs_r1, RSP_VALID, RSP_ID, RSP_F, COMMIT_DONE,
                 exp_cfg_ready, exp_r0, exp_r1, m_rsp_valid, m_rsp_id, m_rsp_f, m_done);
      end
    end
    idle_inputs();
    tick();
    tick();
    read_all();
    n_cmp++; if (obs_table !== m_active) begin n_bad++; $display("FAIL random_table got %h want %h", obs_table, m_active); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_init_lookup();
    test_full_load();
    test_round_robin();
    test_partial();
    test_repeat_addr();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
